// File: rtl/gate_vector_checker.sv
// In-hardware self-test driver/checker for the and/not/and/or gate block.
// Sweeps all eight {a,b,c} vectors, holding each SETTLE+1 cycles, and compares
// i/m/rl/r against per-vector truth tables. Reports error count, first failing vector, pass.
module gate_vector_checker #(
  parameter int         SETTLE = 1,
  parameter logic [7:0] EXP_I  = 8'hC0,
  parameter logic [7:0] EXP_M  = 8'h0F,
  parameter logic [7:0] EXP_RL = 8'h0A,
  parameter logic [7:0] EXP_R  = 8'hCA,
  parameter int         ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c,
  input  logic             i,
  input  logic             m,
  input  logic             rl,
  input  logic             r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [3:0]       mism_bits,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mism_q, mism_d;
  logic [3:0]       mbits_q, mbits_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [2:0]       ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;

  logic             compare;
  logic [3:0]       exp_bits;
  logic [3:0]       diff;

  // Expected response for the vector currently on a/b/c, and the compare strobe
  // that fires on the edge ending the last hold cycle of that vector.
  always_comb begin
    exp_bits = {EXP_I[vec_q], EXP_M[vec_q], EXP_RL[vec_q], EXP_R[vec_q]};
    diff     = {i, m, rl, r} ^ exp_bits;
    compare  = (state_q == DRIVE) && (cnt_q == SETTLE_C);
  end

  // Next-state and next-result logic; mismatch pulse defaults low every cycle.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    mism_d    = 1'b0;
    mbits_d   = 4'd0;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = DRIVE;
          vec_d     = 3'd0;
          cnt_d     = 4'd0;
          err_d     = '0;
          ffv_d     = 3'd0;
          ffvalid_d = 1'b0;
        end
      end
      DRIVE: begin
        if (compare) begin
          if (diff != 4'd0) begin
            mism_d  = 1'b1;
            mbits_d = diff;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
            if (!ffvalid_q) begin
              ffvalid_d = 1'b1;
              ffv_d     = vec_q;
            end
          end
          // The last vector stays on a/b/c through DONE, so vec is left at 7.
          if (vec_q == 3'd7) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 3'd1;
            cnt_d = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        vec_d   = 3'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and result registers with synchronous reset that aborts any sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= 3'd0;
      cnt_q     <= 4'd0;
      mism_q    <= 1'b0;
      mbits_q   <= 4'd0;
      err_q     <= '0;
      ffv_q     <= 3'd0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      mism_q    <= mism_d;
      mbits_q   <= mbits_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  // Stimulus comes straight from the vector register: 0 in IDLE, 7 held in DONE.
  always_comb begin
    {a, b, c}        = vec_q;
    busy             = (state_q == DRIVE);
    done             = (state_q == DONE);
    pass             = (state_q == DONE) && (err_q == '0);
    mismatch         = mism_q;
    mism_bits        = mbits_q;
    err_count        = err_q;
    first_fail_vec   = ffv_q;
    first_fail_valid = ffvalid_q;
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: three instances (SETTLE=1, SETTLE=0, ERR_W=2),
// each driving a modelled gate block whose responses can be corrupted per vector.
// Table sweeps, random sweeps, and a mid-sweep reset are checked every cycle.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] start_v;

  logic a0, b0, c0, i0, m0, rl0, r0, busy0, done0, pass0, mm0, ffva0;
  logic [3:0] mb0, ec0;
  logic [2:0] ff0;
  logic a1, b1, c1, i1, m1, rl1, r1, busy1, done1, pass1, mm1, ffva1;
  logic [3:0] mb1, ec1;
  logic [2:0] ff1;
  logic a2, b2, c2, i2, m2, rl2, r2, busy2, done2, pass2, mm2, ffva2;
  logic [3:0] mb2;
  logic [1:0] ec2;
  logic [2:0] ff2;

  gate_vector_checker #(.SETTLE(1)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a0), .b(b0), .c(c0),
    .i(i0), .m(m0), .rl(rl0), .r(r0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch(mm0), .mism_bits(mb0), .err_count(ec0),
    .first_fail_vec(ff0), .first_fail_valid(ffva0));

  gate_vector_checker #(.SETTLE(0)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a1), .b(b1), .c(c1),
    .i(i1), .m(m1), .rl(rl1), .r(r1), .busy(busy1), .done(done1), .pass(pass1),
    .mismatch(mm1), .mism_bits(mb1), .err_count(ec1),
    .first_fail_vec(ff1), .first_fail_valid(ffva1));

  gate_vector_checker #(.SETTLE(1), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a2), .b(b2), .c(c2),
    .i(i2), .m(m2), .rl(rl2), .r(r2), .busy(busy2), .done(done2), .pass(pass2),
    .mismatch(mm2), .mism_bits(mb2), .err_count(ec2),
    .first_fail_vec(ff2), .first_fail_valid(ffva2));

  // Gate block model: golden logic, optionally corrupted per vector.
  logic [3:0] mask [8];
  logic       stuck_r;

  function automatic logic [3:0] golden(input logic [2:0] v);
    logic aa, bb, cc;
    aa = v[2]; bb = v[1]; cc = v[0];
    return {aa & bb, ~aa, ~aa & cc, (aa & bb) | (~aa & cc)};
  endfunction

  function automatic logic [3:0] gate(input logic [2:0] v, input logic [3:0] mk, input logic st);
    logic [3:0] g;
    g = golden(v) ^ mk;
    if (st) g[0] = 1'b0;
    return g;
  endfunction

  always_comb {i0, m0, rl0, r0} = gate({a0, b0, c0}, mask[{a0, b0, c0}], stuck_r);
  always_comb {i1, m1, rl1, r1} = gate({a1, b1, c1}, mask[{a1, b1, c1}], stuck_r);
  always_comb {i2, m2, rl2, r2} = gate({a2, b2, c2}, mask[{a2, b2, c2}], stuck_r);

  // Observation mux over the three instances.
  int         sel;
  logic       o_busy, o_done, o_pass, o_mm, o_ffva;
  logic [2:0] o_abc, o_ff;
  logic [3:0] o_mb, o_ec;

  always_comb begin
    case (sel)
      1: begin
        o_busy = busy1; o_done = done1; o_pass = pass1; o_mm = mm1; o_ffva = ffva1;
        o_abc = {a1, b1, c1}; o_ff = ff1; o_mb = mb1; o_ec = ec1;
      end
      2: begin
        o_busy = busy2; o_done = done2; o_pass = pass2; o_mm = mm2; o_ffva = ffva2;
        o_abc = {a2, b2, c2}; o_ff = ff2; o_mb = mb2; o_ec = {2'b00, ec2};
      end
      default: begin
        o_busy = busy0; o_done = done0; o_pass = pass0; o_mm = mm0; o_ffva = ffva0;
        o_abc = {a0, b0, c0}; o_ff = ff0; o_mb = mb0; o_ec = ec0;
      end
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Packed observation: {busy,done,pass,abc,mismatch,mism_bits,err_count,ff_vec,ff_valid}
  function automatic logic [31:0] observed();
    return 32'({o_busy, o_done, o_pass, o_abc, o_mm, o_mb, o_ec, o_ff, o_ffva});
  endfunction

  // Runs one sweep on instance d and checks every cycle against a timeline model
  // derived from the hold period P=SETTLE+1 and the per-vector corruption.
  task automatic sweep(input int d, input int extra, input string tag,
                       output logic [3:0] f_ec, output logic [2:0] f_ff,
                       output logic f_ffva, output logic f_pass);
    int P, W, cap, ncmp, fails, first;
    logic [3:0] eff [8];
    logic e_busy, e_done, e_pass, e_mm, e_ffva;
    logic [2:0] e_abc, e_ff;
    logic [3:0] e_mb, e_ec;
    P   = (d == 1) ? 1 : 2;
    W   = (d == 2) ? 2 : 4;
    cap = (1 << W) - 1;
    for (int v = 0; v < 8; v++) eff[v] = gate(3'(v), mask[v], stuck_r) ^ golden(3'(v));
    sel = d;
    @(negedge clk);
    start_v[d] = 1'b1;
    for (int j = 0; j <= 8 * P + 2; j++) begin
      @(negedge clk);
      start_v = 3'b000;
      ncmp = (j / P > 8) ? 8 : j / P;
      fails = 0;
      first = -1;
      for (int v = 0; v < ncmp; v++) begin
        if (eff[v] != 4'd0) begin
          fails++;
          if (first < 0) first = v;
        end
      end
      e_busy = (j < 8 * P);
      e_done = !e_busy;
      e_abc  = e_busy ? 3'(j / P) : 3'd7;
      e_mm   = 1'b0;
      e_mb   = 4'd0;
      if (j >= P && (j % P) == 0 && j <= 8 * P) begin
        e_mb = eff[j / P - 1];
        e_mm = (e_mb != 4'd0);
      end
      e_ec   = 4'((fails > cap) ? cap : fails);
      e_pass = e_done && (fails == 0);
      e_ffva = (first >= 0);
      e_ff   = (first >= 0) ? 3'(first) : 3'd0;
      check($sformatf("%s_cyc%0d", tag, j + 1), observed(),
            32'({e_busy, e_done, e_pass, e_abc, e_mm, e_mb, e_ec, e_ff, e_ffva}));
      if (j == extra) start_v[d] = 1'b1;
    end
    start_v = 3'b000;
    f_ec = o_ec; f_ff = o_ff; f_ffva = o_ffva; f_pass = o_pass;
  endtask

  typedef struct {
    int         dut;
    logic       stuck;
    logic       inv;
    int         extra;
    logic [3:0] x_ec;
    logic [2:0] x_ff;
    logic       x_ffva;
    logic       x_pass;
  } vec_t;

  vec_t       tbl [6];
  logic [3:0] r_ec;
  logic [2:0] r_ff;
  logic       r_ffva, r_pass;

  initial begin
    tbl[0] = '{dut: 0, stuck: 1'b0, inv: 1'b0, extra: -1, x_ec: 4'd0, x_ff: 3'd0, x_ffva: 1'b0, x_pass: 1'b1};
    tbl[1] = '{dut: 0, stuck: 1'b1, inv: 1'b0, extra: -1, x_ec: 4'd4, x_ff: 3'd1, x_ffva: 1'b1, x_pass: 1'b0};
    tbl[2] = '{dut: 0, stuck: 1'b1, inv: 1'b0, extra: 4,  x_ec: 4'd4, x_ff: 3'd1, x_ffva: 1'b1, x_pass: 1'b0};
    tbl[3] = '{dut: 0, stuck: 1'b0, inv: 1'b0, extra: 4,  x_ec: 4'd0, x_ff: 3'd0, x_ffva: 1'b0, x_pass: 1'b1};
    tbl[4] = '{dut: 1, stuck: 1'b0, inv: 1'b0, extra: -1, x_ec: 4'd0, x_ff: 3'd0, x_ffva: 1'b0, x_pass: 1'b1};
    tbl[5] = '{dut: 2, stuck: 1'b0, inv: 1'b1, extra: -1, x_ec: 4'd3, x_ff: 3'd0, x_ffva: 1'b1, x_pass: 1'b0};

    sel     = 0;
    stuck_r = 1'b0;
    for (int v = 0; v < 8; v++) mask[v] = 4'd0;
    start_v = 3'b000;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check($sformatf("reset_dut%0d", d), observed(), 32'd0);
    end
    rst = 1'b0;

    // Table-driven sweeps with fixed end results.
    for (int k = 0; k < 6; k++) begin
      stuck_r = tbl[k].stuck;
      for (int v = 0; v < 8; v++) mask[v] = tbl[k].inv ? 4'hF : 4'h0;
      sweep(tbl[k].dut, tbl[k].extra, $sformatf("tbl%0d", k), r_ec, r_ff, r_ffva, r_pass);
      check($sformatf("tbl%0d_end", k), 32'({r_ec, r_ff, r_ffva, r_pass}),
            32'({tbl[k].x_ec, tbl[k].x_ff, tbl[k].x_ffva, tbl[k].x_pass}));
    end

    // Reset mid-sweep on the SETTLE=1 instance, after vector 0 has already failed.
    stuck_r = 1'b0;
    for (int v = 0; v < 8; v++) mask[v] = 4'd0;
    mask[0] = 4'h1;
    sel = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      start_v = 3'b000;
    end
    check("pre_reset_err", 32'(o_ec), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_state", observed(), 32'd0);
    mask[0] = 4'h0;
    sweep(0, -1, "post_reset", r_ec, r_ff, r_ffva, r_pass);
    check("post_reset_end", 32'({r_ec, r_ff, r_ffva, r_pass}), 32'({4'd0, 3'd0, 1'b0, 1'b1}));

    // Randomized corruption patterns on random instances.
    for (int k = 0; k < 12; k++) begin
      int d, ex;
      d = int'($urandom_range(0, 2));
      stuck_r = ($urandom_range(0, 3) == 0);
      for (int v = 0; v < 8; v++)
        mask[v] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (d == 1) ? 6 : 14)) : -1;
      sweep(d, ex, $sformatf("rnd%0d", k), r_ec, r_ff, r_ffva, r_pass);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Synthesizable stimulus driver and response checker for the and/not/and/or gate block.
- Sweeps all eight {a,b,c} input vectors into the gate block and samples its four outputs (i, m, rl, r) after a programmable settle time.
- Compares each sample against parameterized truth tables, then reports the error count, the first failing vector and an overall pass/done status.
- Sits beside the gate block as its in-hardware self-test counterpart.

Parameters:
- SETTLE, 1: cycles between driving a vector and sampling the gate block's outputs. Legal range 0..15.
- EXP_I, 8'hC0: expected i per vector; bit index = {a,b,c}.
- EXP_M, 8'h0F: expected m per vector; bit index = {a,b,c}.
- EXP_RL, 8'h0A: expected rl per vector; bit index = {a,b,c}.
- EXP_R, 8'hCA: expected r per vector; bit index = {a,b,c}.
- ERR_W, 4: width of the error counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled in IDLE or DONE only.
- a  out  1  stimulus bit 2 of vector.
- b  out  1  stimulus bit 1 of vector.
- c  out  1  stimulus bit 0 of vector.
- i  in  1  gate block output under check.
- m  in  1  gate block output under check.
- rl  in  1  gate block output under check.
- r  in  1  gate block output under check.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until next start or reset.
- pass  out  1  valid while done; 1 when err_count==0.
- mismatch  out  1  one-cycle pulse, cycle after a failing compare.
- mism_bits  out  4  {i,m,rl,r} XOR expected for the pulsed compare; 0 otherwise.
- err_count  out  ERR_W  failing vectors counted, saturating.
- first_fail_vec  out  3  {a,b,c} of first failing vector.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (rst high at a clk edge): state IDLE, a=b=c=0, all other outputs 0. Reset is honoured in every state, including mid-sweep; it aborts the sweep with no done.
- States and transitions:
  - IDLE: start=1 -> DRIVE with vec=0 and the settle counter at 0.
  - DRIVE: a/b/c = vec (registered outputs). The vector is held SETTLE+1 cycles.
  - Compare: on the clk edge ending the last hold cycle (counter==SETTLE), i,m,rl,r are compared with EXP_*[vec].
    - vec<7 -> vec+1, counter cleared, stay in DRIVE.
    - vec==7 -> DONE.
  - DONE: busy=0, done=1, pass=(err_count==0), a/b/c hold 3'b111. start=1 -> DRIVE with vec=0, clearing err_count, first_fail_*, pass and done in that same edge.
- SETTLE=0: the compare happens in the same cycle the vector is first driven, which suits a purely combinational gate block.
- busy: 1 from the cycle after the start edge through the final compare cycle, i.e. 8*(SETTLE+1) cycles.
- done: first high on the cycle immediately after the final compare.
- start while busy: ignored, with no effect on the sweep.
- Compare result:
  - Any mismatching bit makes the vector a failure.
  - err_count increments by 1 per failing vector and saturates at 2^ERR_W-1.
  - mismatch=1 and mism_bits=XOR vector on the cycle after the compare edge; otherwise 0.
- First failure: on the first failing vector of a sweep, first_fail_vec is set to vec and first_fail_valid to 1. Later failures do not overwrite it.
- Inputs i,m,rl,r are used only at compare edges; values at other edges are don't-care.
- vec is a 3-bit counter with no wrap. The sweep ends at 7 and never re-issues vector 0 within a sweep.

Test Plan:
- Golden gate block (i=a&b, m=~a, rl=~a&c, r=i|rl), SETTLE=1, start pulse at cycle 0:
  - a/b/c step 000..111, two cycles each.
  - busy high 16 cycles; done=1 at cycle 17.
  - pass=1, err_count=0, mismatch never pulses, first_fail_valid=0.
- r stuck at 0, SETTLE=1:
  - mismatch pulses for vectors 1,3,6,7 with mism_bits=4'b0001.
  - err_count=4, first_fail_vec=3'b001, pass=0.
- Pulse start again during the sweep (cycle 5) -> ignored; done still at cycle 17 with the same results. Then pulse start in DONE -> counts cleared, a second sweep runs identically.
- Assert rst at cycle 7 mid-sweep -> next cycle busy=0, a=b=c=0, err_count=0, done=0. A later start runs a full clean sweep.
- SETTLE=0, combinational golden gate block -> each vector held one cycle, busy 8 cycles, pass=1.
- ERR_W=2, all four outputs inverted -> 8 failures, err_count saturates at 3, mism_bits=4'b1111 on every pulse, first_fail_vec=3'b000.
